// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locked arbiter sharing one UART TX byte
//               interface between N_REQ byte-stream requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDX_W-1:0] r_owner;
  logic [c_IDX_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_burst;
  logic [N_REQ-1:0]   r_grant;
  logic               r_busy;

  logic               w_found;
  logic [c_IDX_W-1:0] w_pick;
  logic [c_IDX_W-1:0] w_cand;
  logic [N_REQ-1:0]   w_pick_oh;
  logic [c_IDX_W-1:0] w_ptr_next;
  logic               w_xfer;
  logic               w_release;

  // Scan from the far end back towards ptr so the nearest requester wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (int'(r_ptr) + k >= N_REQ) begin
        w_cand = c_IDX_W'(int'(r_ptr) + k - N_REQ);
      end else begin
        w_cand = c_IDX_W'(int'(r_ptr) + k);
      end
      if (req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_ptr_next = (r_owner == c_IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

  assign tx_valid  = r_busy & req_valid[r_owner];
  assign tx_data   = req_data[{r_owner, 3'b000} +: 8];
  assign req_ready = r_grant & {N_REQ{r_busy & tx_ready}};
  assign grant     = r_grant;
  assign busy      = r_busy;

  assign w_xfer    = tx_valid & tx_ready;
  assign w_release = w_xfer & (req_last[r_owner] | (r_burst == c_CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_owner <= w_pick;
            r_grant <= w_pick_oh;
            r_busy  <= 1'b1;
            r_burst <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_burst <= '0;
          end else if (w_xfer) begin
            r_burst <= r_burst + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
